// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, forward
// selects, control-word bit positions, the stage-control bundle and the forward rule.
package hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_MWAIT = 1'b1;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Bit positions inside the decoded control_signal word
  localparam int CS_REGDST   = 0;
  localparam int CS_REGWRITE = 1;
  localparam int CS_ALUSRC   = 2;
  localparam int CS_ALUOP_LO = 4;
  localparam int CS_ALUOP_HI = 5;
  localparam int CS_MEMTOREG = 6;
  localparam int CS_MEMWRITE = 7;
  localparam int CS_MEMREAD  = 8;

  typedef struct packed {
    logic pc_en;
    logic d_en;
    logic ex_en;
    logic mem_en;
    logic d_flush;
    logic ex_flush;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_RUN    = 6'b111100;
  localparam stage_ctl_t CTL_FREEZE = 6'b000000;
  localparam stage_ctl_t CTL_BRANCH = 6'b111111;
  localparam stage_ctl_t CTL_BUBBLE = 6'b001101;

  // Nearest producer wins; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] src
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) return FWD_MEM;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))    return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward.sv
// ALU operand forwarding: one selector per Execute source register.
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_write_register,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_register,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][4:0] src;
  logic [NUM_SRC-1:0][1:0] sel;

  assign src = {ex_rt, ex_rs};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign sel[i] = fwd_pick(mem_reg_write, mem_write_register,
                             wb_reg_write, wb_write_register, src[i]);
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: DMEM wait freeze with timeout release, branch flush,
// load-use bubble, operand forwarding and saturating stall/flush statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
)(
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_uses_rt,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_write_register,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_write_register,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_write_register,
  input  logic             EX_branch_taken,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_en,
  output logic             D_en,
  output logic             EX_en,
  output logic             MEM_en,
  output logic             D_flush,
  output logic             EX_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [0:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              force_rel;
  logic              freeze;
  logic              load_use;
  logic              branch_flush;
  logic              unused_ex_regwrite;
  stage_ctl_t        ctl;
  logic [1:0]        fwd_a_raw;
  logic [1:0]        fwd_b_raw;

  // Execute-stage RegWrite does not affect any hazard decision here.
  assign unused_ex_regwrite = EX_RegWrite;

  assign freeze   = MEM_req & ~MEM_ready & ~force_rel;
  assign load_use = EX_MemRead & (EX_write_register != 5'd0) &
                    ((EX_write_register == D_rs) |
                     (D_uses_rt & (EX_write_register == D_rt)));

  // The release cycle after a timeout drives every enable high, so it also
  // overrides a load-use bubble.
  always_comb begin
    ctl = CTL_RUN;
    if (SYS_reset)                    ctl = CTL_RUN;
    else if (freeze)                  ctl = CTL_FREEZE;
    else if (EX_branch_taken)         ctl = CTL_BRANCH;
    else if (load_use && !force_rel)  ctl = CTL_BUBBLE;
  end

  assign branch_flush = ~SYS_reset & ~freeze & EX_branch_taken;
  assign {PC_en, D_en, EX_en, MEM_en, D_flush, EX_flush} = ctl;

  forward_unit u_fwd (
    .ex_rs              (EX_rs),
    .ex_rt              (EX_rt),
    .mem_reg_write      (MEM_RegWrite),
    .mem_write_register (MEM_write_register),
    .wb_reg_write       (WB_RegWrite),
    .wb_write_register  (WB_write_register),
    .fwd_a              (fwd_a_raw),
    .fwd_b              (fwd_b_raw)
  );

  assign fwd_a = SYS_reset ? FWD_REG : fwd_a_raw;
  assign fwd_b = SYS_reset ? FWD_REG : fwd_b_raw;

  // The freeze cycle that enters MWAIT counts as the first wait cycle.
  assign wait_inc = (state == ST_MWAIT) ? wait_cnt + WAIT_W'(1) : WAIT_W'(1);

  always_ff @(negedge SYS_clk) begin
    if (SYS_reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      force_rel   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      force_rel <= 1'b0;
      if (freeze) begin
        if (wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
          timeout_err <= 1'b1;
          force_rel   <= 1'b1;
          state       <= ST_RUN;
          wait_cnt    <= '0;
        end else begin
          state    <= ST_MWAIT;
          wait_cnt <= wait_inc;
        end
      end else begin
        state    <= ST_RUN;
        wait_cnt <= '0;
      end
    end
  end

  always_ff @(negedge SYS_clk) begin
    if (SYS_reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a cycle-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TMO = 16;

  logic SYS_clk = 1'b0;
  logic SYS_reset;
  logic [4:0] D_rs, D_rt, EX_rs, EX_rt, EX_write_register, MEM_write_register, WB_write_register;
  logic D_uses_rt, EX_MemRead, EX_RegWrite, MEM_RegWrite, WB_RegWrite;
  logic EX_branch_taken, MEM_req, MEM_ready;
  logic PC_en, D_en, EX_en, MEM_en, D_flush, EX_flush, timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic PC_en4, D_en4, EX_en4, MEM_en4, D_flush4, EX_flush4, timeout_err4;
  logic [1:0] fwd_a4, fwd_b4;
  logic [3:0] stall_cnt4, flush_cnt4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 SYS_clk = ~SYS_clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .D_rs(D_rs), .D_rt(D_rt), .D_uses_rt(D_uses_rt),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_write_register(EX_write_register), .MEM_RegWrite(MEM_RegWrite),
    .MEM_write_register(MEM_write_register), .WB_RegWrite(WB_RegWrite),
    .WB_write_register(WB_write_register), .EX_branch_taken(EX_branch_taken),
    .MEM_req(MEM_req), .MEM_ready(MEM_ready), .PC_en(PC_en), .D_en(D_en), .EX_en(EX_en),
    .MEM_en(MEM_en), .D_flush(D_flush), .EX_flush(EX_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err));

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut4 (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .D_rs(D_rs), .D_rt(D_rt), .D_uses_rt(D_uses_rt),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_write_register(EX_write_register), .MEM_RegWrite(MEM_RegWrite),
    .MEM_write_register(MEM_write_register), .WB_RegWrite(WB_RegWrite),
    .WB_write_register(WB_write_register), .EX_branch_taken(EX_branch_taken),
    .MEM_req(MEM_req), .MEM_ready(MEM_ready), .PC_en(PC_en4), .D_en(D_en4), .EX_en(EX_en4),
    .MEM_en(MEM_en4), .D_flush(D_flush4), .EX_flush(EX_flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .timeout_err(timeout_err4));

  typedef struct {
    logic       rst;
    logic [4:0] d_rs, d_rt;
    logic       uses_rt;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_mr, ex_rw;
    logic [4:0] ex_wr;
    logic       mem_rw;
    logic [4:0] mem_wr;
    logic       wb_rw;
    logic [4:0] wb_wr;
    logic       br, req, rdy;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int ctl_now();
    return int'({PC_en, D_en, EX_en, MEM_en, D_flush, EX_flush});
  endfunction

  // Reference forward rule, written directly from the register-match description.
  function automatic int ref_fwd(input logic mw, input logic [4:0] mr, input logic ww,
                                 input logic [4:0] wr, input logic [4:0] s);
    if (s == 0) return 0;
    if (mw && mr == s) return 2;
    if (ww && wr == s) return 1;
    return 0;
  endfunction

  task automatic step();
    @(negedge SYS_clk);
    #1;
  endtask

  task automatic clr_in();
    {D_rs, D_rt, EX_rs, EX_rt, EX_write_register, MEM_write_register, WB_write_register} = '0;
    {D_uses_rt, EX_MemRead, EX_RegWrite, MEM_RegWrite, WB_RegWrite} = '0;
    {EX_branch_taken, MEM_req, MEM_ready} = '0;
  endtask

  task automatic do_reset();
    SYS_reset = 1'b1;
    clr_in();
    step();
    SYS_reset = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    SYS_reset = v.rst; D_rs = v.d_rs; D_rt = v.d_rt; D_uses_rt = v.uses_rt;
    EX_rs = v.ex_rs; EX_rt = v.ex_rt; EX_MemRead = v.ex_mr; EX_RegWrite = v.ex_rw;
    EX_write_register = v.ex_wr; MEM_RegWrite = v.mem_rw; MEM_write_register = v.mem_wr;
    WB_RegWrite = v.wb_rw; WB_write_register = v.wb_wr; EX_branch_taken = v.br;
    MEM_req = v.req; MEM_ready = v.rdy;
  endtask

  function automatic vec_t vbase();
    vec_t v;
    v = '{rst: 1'b0, d_rs: 5'd0, d_rt: 5'd0, uses_rt: 1'b0, ex_rs: 5'd0, ex_rt: 5'd0,
          ex_mr: 1'b0, ex_rw: 1'b0, ex_wr: 5'd0, mem_rw: 1'b0, mem_wr: 5'd0,
          wb_rw: 1'b0, wb_wr: 5'd0, br: 1'b0, req: 1'b0, rdy: 1'b0,
          ctl: 6'b111100, fa: 2'b00, fb: 2'b00};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_waits, m_stall, m_stall4, m_flush, m_flush4;
    logic m_rel, m_err, slow, fr, lu;
    int e_ctl;

    // ---- vector table: single-cycle combinational decisions from a clean RUN state
    for (int i = 0; i < 14; i++) vt[i] = vbase();
    vt[1].ex_mr = 1; vt[1].ex_wr = 2; vt[1].d_rs = 2; vt[1].ctl = 6'b001101;
    vt[2].ex_mr = 1; vt[2].ex_wr = 7; vt[2].d_rt = 7; vt[2].uses_rt = 1; vt[2].ctl = 6'b001101;
    vt[3].ex_mr = 1; vt[3].ex_wr = 7; vt[3].d_rt = 7; vt[3].uses_rt = 0;
    vt[4].ex_mr = 1; vt[4].ex_wr = 0; vt[4].d_rs = 0; vt[4].uses_rt = 1;
    vt[5].ex_mr = 1; vt[5].ex_wr = 3; vt[5].d_rs = 3; vt[5].br = 1; vt[5].ctl = 6'b111111;
    vt[6].req = 1; vt[6].rdy = 0; vt[6].br = 1; vt[6].ctl = 6'b000000;
    vt[7].req = 1; vt[7].rdy = 1;
    vt[8].mem_rw = 1; vt[8].mem_wr = 5; vt[8].ex_rs = 5; vt[8].ex_rt = 5; vt[8].fa = 2; vt[8].fb = 2;
    vt[9].mem_rw = 1; vt[9].mem_wr = 6; vt[9].wb_rw = 1; vt[9].wb_wr = 6; vt[9].ex_rt = 6; vt[9].fb = 2;
    vt[10].wb_rw = 1; vt[10].wb_wr = 4; vt[10].ex_rs = 3; vt[10].ex_rt = 4; vt[10].fb = 1;
    vt[11].mem_rw = 1; vt[11].wb_rw = 1;
    vt[12].mem_wr = 5; vt[12].wb_rw = 1; vt[12].wb_wr = 5; vt[12].ex_rs = 5; vt[12].fa = 1;
    vt[13].rst = 1; vt[13].ex_mr = 1; vt[13].ex_wr = 2; vt[13].d_rs = 2; vt[13].br = 1;
    vt[13].req = 1; vt[13].mem_rw = 1; vt[13].mem_wr = 9; vt[13].ex_rs = 9;

    SYS_reset = 1'b1;
    clr_in();
    step();
    chk("reset_stall", int'(stall_cnt), 0);
    chk("reset_flush", int'(flush_cnt), 0);
    chk("reset_timeout", int'(timeout_err), 0);
    chk("reset_state", int'(dut.state), int'(ST_RUN));

    for (int i = 0; i < 14; i++) begin
      do_reset();
      apply(vt[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl_now(), int'(vt[i].ctl));
      chk($sformatf("vec%0d_fwd_a", i), int'(fwd_a), int'(vt[i].fa));
      chk($sformatf("vec%0d_fwd_b", i), int'(fwd_b), int'(vt[i].fb));
    end

    // ---- lw $2 ; add $3,$2,$4 : one bubble then WB forward
    do_reset();
    EX_MemRead = 1; EX_RegWrite = 1; EX_write_register = 2;
    D_rs = 2; D_rt = 4; D_uses_rt = 1;
    #1 chk("lu_bubble", ctl_now(), 6'b001101);
    step();
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    EX_MemRead = 0; EX_RegWrite = 0; EX_write_register = 0;
    MEM_RegWrite = 1; MEM_write_register = 2;
    #1 chk("lu_resume", ctl_now(), 6'b111100);
    step();
    D_rs = 0; D_rt = 0; D_uses_rt = 0;
    EX_rs = 2; EX_rt = 4; EX_RegWrite = 1; EX_write_register = 3;
    MEM_RegWrite = 0; MEM_write_register = 0; WB_RegWrite = 1; WB_write_register = 2;
    #1 chk("lu_fwd_a_wb", int'(fwd_a), 1);
    chk("lu_fwd_b_reg", int'(fwd_b), 0);
    step();
    chk("lu_stall_once", int'(stall_cnt), 1);

    // ---- add $5 ; sub $6,$5,$5 then $0 traffic
    do_reset();
    MEM_RegWrite = 1; MEM_write_register = 5; EX_rs = 5; EX_rt = 5;
    #1 chk("alu_fwd_a_mem", int'(fwd_a), 2);
    chk("alu_fwd_b_mem", int'(fwd_b), 2);
    chk("alu_no_stall", int'(PC_en), 1);
    step();
    MEM_write_register = 0; EX_rs = 0; EX_rt = 0; WB_RegWrite = 1; WB_write_register = 0;
    #1 chk("r0_fwd_a", int'(fwd_a), 0);
    chk("r0_fwd_b", int'(fwd_b), 0);
    step();
    chk("alu_stall_cnt", int'(stall_cnt), 0);

    // ---- branch taken with a coincident load-use
    do_reset();
    EX_branch_taken = 1; EX_MemRead = 1; EX_write_register = 8; D_rs = 8;
    #1 chk("br_lu_ctl", ctl_now(), 6'b111111);
    step();
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 0);

    // ---- short DMEM wait
    do_reset();
    MEM_req = 1; MEM_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mw_freeze%0d", k), ctl_now(), 0);
      step();
      chk($sformatf("mw_state%0d", k), int'(dut.state), int'(ST_MWAIT));
    end
    MEM_ready = 1;
    #1 chk("mw_ready_ctl", ctl_now(), 6'b111100);
    step();
    chk("mw_back_run", int'(dut.state), int'(ST_RUN));
    chk("mw_no_timeout", int'(timeout_err), 0);
    chk("mw_stall_cnt", int'(stall_cnt), 3);

    // ---- DMEM timeout, release, re-freeze, reset during MWAIT
    do_reset();
    MEM_req = 1; MEM_ready = 0;
    for (int k = 0; k < TMO; k++) begin
      #1 chk($sformatf("to_freeze%0d", k), ctl_now(), 0);
      step();
      if (k < TMO - 1) chk($sformatf("to_err_low%0d", k), int'(timeout_err), 0);
    end
    chk("to_err_set", int'(timeout_err), 1);
    chk("to_state_run", int'(dut.state), int'(ST_RUN));
    #1 chk("to_release", ctl_now(), 6'b111100);
    step();
    #1 chk("to_refreeze", ctl_now(), 0);
    step();
    chk("to_mwait_again", int'(dut.state), int'(ST_MWAIT));
    chk("to_err_sticky", int'(timeout_err), 1);
    SYS_reset = 1;
    #1 chk("to_rst_ctl", ctl_now(), 6'b111100);
    step();
    SYS_reset = 0;
    chk("to_rst_err", int'(timeout_err), 0);
    chk("to_rst_state", int'(dut.state), int'(ST_RUN));
    chk("to_rst_stall", int'(stall_cnt), 0);

    // ---- saturation with a 4-bit counter
    do_reset();
    EX_MemRead = 1; EX_write_register = 4; D_rs = 4;
    for (int k = 0; k < 20; k++) step();
    chk("sat_stall4", int'(stall_cnt4), 15);
    chk("sat_stall16", int'(stall_cnt), 20);

    // ---- randomized run against the reference model
    do_reset();
    m_waits = 0; m_stall = 0; m_stall4 = 0; m_flush = 0; m_flush4 = 0;
    m_rel = 0; m_err = 0; slow = 0;
    for (int c = 0; c < 1500; c++) begin
      SYS_reset = ($urandom_range(0, 79) == 0);
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      D_uses_rt = 1'($urandom); EX_rs = 5'($urandom_range(0, 3)); EX_rt = 5'($urandom_range(0, 3));
      EX_MemRead = ($urandom_range(0, 2) == 0); EX_RegWrite = 1'($urandom);
      EX_write_register = 5'($urandom_range(0, 3));
      MEM_RegWrite = 1'($urandom); MEM_write_register = 5'($urandom_range(0, 3));
      WB_RegWrite = 1'($urandom); WB_write_register = 5'($urandom_range(0, 3));
      EX_branch_taken = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) slow = ~slow;
      MEM_req = slow ? 1'b1 : ($urandom_range(0, 3) == 0);
      MEM_ready = slow ? 1'b0 : ($urandom_range(0, 2) != 0);

      fr = !SYS_reset && MEM_req && !MEM_ready && !m_rel;
      lu = EX_MemRead && EX_write_register != 0 &&
           (EX_write_register == D_rs || (D_uses_rt && EX_write_register == D_rt));
      if (SYS_reset)                 e_ctl = 6'b111100;
      else if (fr)                   e_ctl = 6'b000000;
      else if (EX_branch_taken)      e_ctl = 6'b111111;
      else if (lu && !m_rel)         e_ctl = 6'b001101;
      else                           e_ctl = 6'b111100;
      #1;
      chk("rnd_ctl", ctl_now(), e_ctl);
      chk("rnd_fwd_a", int'(fwd_a), SYS_reset ? 0 :
          ref_fwd(MEM_RegWrite, MEM_write_register, WB_RegWrite, WB_write_register, EX_rs));
      chk("rnd_fwd_b", int'(fwd_b), SYS_reset ? 0 :
          ref_fwd(MEM_RegWrite, MEM_write_register, WB_RegWrite, WB_write_register, EX_rt));
      step();
      if (SYS_reset) begin
        m_waits = 0; m_stall = 0; m_stall4 = 0; m_flush = 0; m_flush4 = 0;
        m_rel = 0; m_err = 0;
      end else begin
        if (e_ctl[5] == 1'b0) begin
          if (m_stall < 65535) m_stall++;
          if (m_stall4 < 15) m_stall4++;
        end
        if (!fr && EX_branch_taken) begin
          if (m_flush < 65535) m_flush++;
          if (m_flush4 < 15) m_flush4++;
        end
        m_rel = 0;
        if (fr) begin
          m_waits++;
          if (m_waits >= TMO) begin
            m_err = 1; m_rel = 1; m_waits = 0;
          end
        end else begin
          m_waits = 0;
        end
      end
      chk("rnd_stall", int'(stall_cnt), m_stall);
      chk("rnd_stall4", int'(stall_cnt4), m_stall4);
      chk("rnd_flush", int'(flush_cnt), m_flush);
      chk("rnd_flush4", int'(flush_cnt4), m_flush4);
      chk("rnd_timeout", int'(timeout_err), int'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
